// File: rtl/sha_block_loader.sv
// Streams message words into 512-bit block memory, one word per write strobe.
// Define SHA_PAD_EN to append the 1-bit, zero fill and 64-bit length trailer.
module sha_block_loader #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned MAX_BLOCKS = 64,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       msg_len,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  output logic              cs_n,
  output logic              wr_n,
  output logic [ADDR_W-1:0] addr,
  output logic [8:0]        addr_width,
  output logic [WORD_W-1:0] bram_data_in,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic [ADDR_W-1:0] n_blocks
);
  localparam int unsigned WPB   = 512 / WORD_W;
  localparam int unsigned IDX_W = $clog2(WPB);
  localparam int unsigned WSH   = $clog2(WORD_W);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD1, S_ZERO, S_LEN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [33:0]       blocks_c;
  logic              len_bad_c;
  logic [31:0]       words_c;
  logic              xfer_c;
  logic              wr_c;
  logic [WORD_W-1:0] wdata_c;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt_c;
  logic [ADDR_W-1:0] blk_q, blk_d;
  logic [31:0]       words_q, words_d;
  logic              cs_n_q, cs_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        aw_q, aw_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] nblk_q, nblk_d;
`ifdef SHA_PAD_EN
  localparam logic [IDX_W-1:0] LEN_IDX = IDX_W'((512 - 64) / WORD_W);
  logic [31:0] len_q, len_d;
  logic        lsel_q, lsel_d;
  logic [63:0] len64_c;

  // Room for the trailer: one marker bit plus 64 length bits.
  assign blocks_c  = (34'(msg_len) + 34'd576) >> 9;
  assign len_bad_c = blocks_c > 34'(MAX_BLOCKS);
  assign len64_c   = {32'd0, len_q};
`else
  assign blocks_c  = 34'(msg_len >> 9);
  assign len_bad_c = (blocks_c == 34'd0) || (msg_len[8:0] != 9'd0) ||
                     (blocks_c > 34'(MAX_BLOCKS));
`endif

  assign words_c   = msg_len >> WSH;
  assign xfer_c    = in_valid & ready_q;
  assign idx_nxt_c = idx_q + IDX_W'(1);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !len_bad_c) begin
`ifdef SHA_PAD_EN
          state_d = (words_c == 32'd0) ? S_PAD1 : S_LOAD;
`else
          state_d = S_LOAD;
`endif
        end
      end
      S_LOAD: begin
        if (xfer_c && (words_q == 32'd1)) begin
`ifdef SHA_PAD_EN
          state_d = S_PAD1;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SHA_PAD_EN
      S_PAD1, S_ZERO: state_d = (idx_nxt_c == LEN_IDX) ? S_LEN : S_ZERO;
      S_LEN:          if ((WORD_W == 64) || lsel_q) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write generation, block/word position tracking and registered outputs.
  always_comb begin
    wr_c    = 1'b0;
    wdata_c = '0;
    idx_d   = idx_q;
    blk_d   = blk_q;
    words_d = words_q;
    nblk_d  = nblk_q;
    err_d   = 1'b0;
`ifdef SHA_PAD_EN
    len_d   = len_q;
    lsel_d  = lsel_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_bad_c) begin
            err_d = 1'b1;
          end else begin
            idx_d   = '0;
            blk_d   = '0;
            words_d = words_c;
            nblk_d  = ADDR_W'(blocks_c);
`ifdef SHA_PAD_EN
            len_d   = msg_len;
            lsel_d  = 1'b0;
`endif
          end
        end
      end
      S_LOAD: begin
        if (xfer_c) begin
          wr_c    = 1'b1;
          wdata_c = in_word;
          words_d = words_q - 32'd1;
        end
      end
`ifdef SHA_PAD_EN
      S_PAD1: begin
        wr_c    = 1'b1;
        wdata_c = {1'b1, {(WORD_W-1){1'b0}}};
      end
      S_ZERO: wr_c = 1'b1;
      S_LEN: begin
        wr_c    = 1'b1;
        wdata_c = WORD_W'(lsel_q ? len64_c : (len64_c >> (64 - WORD_W)));
        lsel_d  = 1'b1;
      end
`endif
      default: ;
    endcase
    if (wr_c) begin
      idx_d = idx_nxt_c;
      if (idx_q == IDX_W'(WPB - 1)) blk_d = blk_q + ADDR_W'(1);
    end
    cs_n_d  = ~wr_c;
    addr_d  = wr_c ? blk_q : addr_q;
    aw_d    = wr_c ? (9'd511 - (9'(idx_q) << WSH)) : aw_q;
    data_d  = wr_c ? wdata_c : data_q;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      blk_q   <= '0;
      words_q <= '0;
      cs_n_q  <= 1'b1;
      addr_q  <= '0;
      aw_q    <= 9'd511;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      nblk_q  <= '0;
`ifdef SHA_PAD_EN
      len_q   <= '0;
      lsel_q  <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      words_q <= words_d;
      cs_n_q  <= cs_n_d;
      addr_q  <= addr_d;
      aw_q    <= aw_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      nblk_q  <= nblk_d;
`ifdef SHA_PAD_EN
      len_q   <= len_d;
      lsel_q  <= lsel_d;
`endif
    end
  end

  assign in_ready     = ready_q;
  assign cs_n         = cs_n_q;
  assign wr_n         = cs_n_q;
  assign addr         = addr_q;
  assign addr_width   = aw_q;
  assign bram_data_in = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_len      = err_q;
  assign n_blocks     = nblk_q;
endmodule

// File: tb/tb_sha_block_loader.sv
// Bench for sha_block_loader: a 32-bit/64-block instance and a 64-bit/2-block
// instance, both checked against a whole-message block image model.
`timescale 1ns/1ps
module tb_sha_block_loader;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start, in_valid, sel;
  logic [31:0] msg_len;
  logic [63:0] in_word;

  logic        ready_a, cs_n_a, wr_n_a, busy_a, done_a, err_a;
  logic [15:0] addr_a, nb_a;
  logic [8:0]  aw_a;
  logic [31:0] data_a;
  logic        ready_b, cs_n_b, wr_n_b, busy_b, done_b, err_b;
  logic [15:0] addr_b, nb_b;
  logic [8:0]  aw_b;
  logic [63:0] data_b;

  logic        ready_m, cs_n_m, wr_n_m, busy_m, done_m, err_m;
  logic [15:0] addr_m, nb_m;
  logic [8:0]  aw_m;
  logic [63:0] data_m;

  typedef struct packed {
    logic [15:0] addr;
    logic [8:0]  aw;
    logic [63:0] data;
    logic        wr_n;
  } wr_t;

  wr_t         wr_q[$];
  wr_t         exp_q[$];
  logic [63:0] msg_q[$];
  int          done_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int          n_cmp = 0, n_fail = 0;

  always #5 clock = ~clock;

  sha_block_loader #(.WORD_W(32), .MAX_BLOCKS(64), .ADDR_W(16)) u_dut_a (
    .clock(clock), .reset(reset), .start(start & ~sel), .msg_len(msg_len),
    .in_valid(in_valid & ~sel), .in_word(in_word[31:0]), .in_ready(ready_a),
    .cs_n(cs_n_a), .wr_n(wr_n_a), .addr(addr_a), .addr_width(aw_a),
    .bram_data_in(data_a), .busy(busy_a), .done(done_a), .err_len(err_a),
    .n_blocks(nb_a));

  sha_block_loader #(.WORD_W(64), .MAX_BLOCKS(2), .ADDR_W(16)) u_dut_b (
    .clock(clock), .reset(reset), .start(start & sel), .msg_len(msg_len),
    .in_valid(in_valid & sel), .in_word(in_word), .in_ready(ready_b),
    .cs_n(cs_n_b), .wr_n(wr_n_b), .addr(addr_b), .addr_width(aw_b),
    .bram_data_in(data_b), .busy(busy_b), .done(done_b), .err_len(err_b),
    .n_blocks(nb_b));

  assign ready_m = sel ? ready_b : ready_a;
  assign cs_n_m  = sel ? cs_n_b  : cs_n_a;
  assign wr_n_m  = sel ? wr_n_b  : wr_n_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign err_m   = sel ? err_b   : err_a;
  assign addr_m  = sel ? addr_b  : addr_a;
  assign nb_m    = sel ? nb_b    : nb_a;
  assign aw_m    = sel ? aw_b    : aw_a;
  assign data_m  = sel ? data_b  : {32'd0, data_a};

  // Record every memory write strobe and pulse of the selected instance.
  always @(negedge clock) begin
    if (!reset) begin
      if (!cs_n_m) wr_q.push_back('{addr_m, aw_m, data_m, wr_n_m});
      if (done_m) done_cnt++;
      if (err_m)  err_cnt++;
      if (busy_m) busy_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Lay the message out as an image of whole blocks, then list it word by word.
  task automatic build_exp(input bit s, input int unsigned len, output int unsigned nb);
    int unsigned w, wpb, nw, total;
    logic [63:0] img[$];
    w = s ? 64 : 32;
    wpb = 512 / w;
    nw = len / w;
    exp_q.delete();
`ifdef SHA_PAD_EN
    nb = (len + 1 + 64 + 511) / 512;
    total = nb * wpb;
    for (int i = 0; i < int'(total); i++) img.push_back(64'd0);
    for (int i = 0; i < int'(nw); i++) img[i] = msg_q[i];
    img[nw] = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    img[total-1] = (w == 64) ? 64'(len) : 64'(len & 32'hffff_ffff);
    if (w == 32) img[total-2] = 64'd0;
`else
    nb = len / 512;
    total = nw;
    img = msg_q;
`endif
    for (int k = 0; k < int'(total); k++)
      exp_q.push_back('{16'(k / wpb), 9'(511 - w * (k % wpb)), img[k], 1'b0});
  endtask

  task automatic run_msg(input bit s, input int unsigned len, input bit toggle,
                         input bit poke, input string name);
    int unsigned w, nw, nb, wb, db, cyc, k, ngot;
    w = s ? 64 : 32;
    nw = len / w;
    msg_q.delete();
    for (int i = 0; i < int'(nw); i++)
      msg_q.push_back(s ? {$urandom, $urandom} : 64'($urandom));
    build_exp(s, len, nb);
    sel = s;
    wb = wr_q.size();
    db = done_cnt;
    msg_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < nw && cyc < 4000) begin
      start = poke && (cyc == 2);
      msg_len = start ? len + 512 : len;
      in_valid = toggle ? (cyc % 2 == 0) : ($urandom_range(3, 0) != 0);
      in_word = msg_q[k];
      if (in_valid && ready_m) k++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    msg_len = len;
    while (!done_m && cyc < 4000) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (!done_m) begin
      n_fail++;
      $display("FAIL %s done_timeout: got done=%b after %0d cycles, expected done=1", name, done_m, cyc);
    end
    repeat (3) tick();
    ngot = wr_q.size() - wb;
    n_cmp++;
    if (ngot !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d expected %0d", name, ngot, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < int'(ngot); i++) begin
      n_cmp++;
      if (wr_q[wb + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s write %0d: got addr=%0d width=%0d data=%h wr_n=%b expected addr=%0d width=%0d data=%h wr_n=%b",
                 name, i, wr_q[wb+i].addr, wr_q[wb+i].aw, wr_q[wb+i].data, wr_q[wb+i].wr_n,
                 exp_q[i].addr, exp_q[i].aw, exp_q[i].data, exp_q[i].wr_n);
      end
    end
    n_cmp++;
    if (nb_m !== 16'(nb)) begin
      n_fail++;
      $display("FAIL %s n_blocks: got %0d expected %0d", name, nb_m, nb);
    end
    n_cmp++;
    if ((done_cnt - db) !== 1 || busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: got %0d done cycles busy=%b expected 1 and busy=0", name, done_cnt - db, busy_m);
    end
  endtask

  task automatic test_len_err(input bit s, input int unsigned len, input string name);
    int wb, eb, bb;
    sel = s;
    wb = wr_q.size();
    eb = err_cnt;
    bb = busy_cnt;
    msg_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if ((err_cnt - eb) !== 1 || (busy_cnt - bb) !== 0 || (wr_q.size() - wb) !== 0) begin
      n_fail++;
      $display("FAIL %s err_len: got err_cycles=%0d busy_cycles=%0d writes=%0d expected 1/0/0",
               name, err_cnt - eb, busy_cnt - bb, wr_q.size() - wb);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({ready_a, cs_n_a, wr_n_a, addr_a, aw_a, data_a, busy_a, done_a, err_a, nb_a} !==
        {1'b0, 1'b1, 1'b1, 16'd0, 9'd511, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_a: got rdy=%b cs_n=%b wr_n=%b addr=%0d width=%0d data=%h busy=%b done=%b err=%b nb=%0d expected 0 1 1 0 511 0 0 0 0 0",
               ready_a, cs_n_a, wr_n_a, addr_a, aw_a, data_a, busy_a, done_a, err_a, nb_a);
    end
    n_cmp++;
    if ({ready_b, cs_n_b, wr_n_b, addr_b, aw_b, data_b, busy_b, done_b, err_b, nb_b} !==
        {1'b0, 1'b1, 1'b1, 16'd0, 9'd511, 64'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_b: got rdy=%b cs_n=%b wr_n=%b addr=%0d width=%0d data=%h busy=%b done=%b err=%b nb=%0d expected 0 1 1 0 511 0 0 0 0 0",
               ready_b, cs_n_b, wr_n_b, addr_b, aw_b, data_b, busy_b, done_b, err_b, nb_b);
    end
  endtask

  task automatic test_known();
`ifdef SHA_PAD_EN
    run_msg(1'b0, 1024, 1'b0, 1'b0, "len1024");
    run_msg(1'b0, 416, 1'b0, 1'b0, "len416");
    run_msg(1'b0, 448, 1'b0, 1'b0, "len448");
    run_msg(1'b0, 0, 1'b0, 1'b0, "len0");
    run_msg(1'b1, 896, 1'b0, 1'b0, "w64_len896");
`else
    run_msg(1'b0, 512, 1'b0, 1'b0, "len512");
    run_msg(1'b0, 1024, 1'b0, 1'b0, "len1024");
    run_msg(1'b1, 1024, 1'b0, 1'b0, "w64_len1024");
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
`ifdef SHA_PAD_EN
      run_msg(1'b0, 32 * $urandom_range(60, 0), 1'b0, 1'b0, "rand_w32");
      run_msg(1'b1, 64 * $urandom_range(14, 0), 1'b0, 1'b0, "rand_w64");
`else
      run_msg(1'b0, 512 * $urandom_range(4, 1), 1'b0, 1'b0, "rand_w32");
      run_msg(1'b1, 512 * $urandom_range(2, 1), 1'b0, 1'b0, "rand_w64");
`endif
    end
  endtask

  task automatic test_len_limits();
`ifdef SHA_PAD_EN
    test_len_err(1'b1, 1024, "max2_len1024");
    test_len_err(1'b1, 960, "max2_len960");
    test_len_err(1'b0, 32704, "max64_len32704");
`else
    test_len_err(1'b0, 0, "len0");
    test_len_err(1'b1, 1536, "max2_len1536");
    test_len_err(1'b0, 33280, "max64_len33280");
`endif
  endtask

  task automatic test_reset_mid();
    int k, cyc;
    sel = 1'b0;
    msg_len = 1024;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 100) begin
      in_word = 64'($urandom);
      if (ready_m) k++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    test_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
`ifdef SHA_PAD_EN
    run_msg(1'b0, 32, 1'b0, 1'b0, "after_reset");
`else
    run_msg(1'b0, 512, 1'b0, 1'b0, "after_reset");
`endif
  endtask

  initial begin
    start = 1'b0;
    msg_len = '0;
    in_valid = 1'b0;
    in_word = '0;
    sel = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    tick();
    test_known();
    test_random();
    test_len_limits();
    run_msg(1'b0, 1024, 1'b0, 1'b1, "start_while_busy");
    test_reset_mid();
    run_msg(1'b1, 512, 1'b1, 1'b0, "w64_toggle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
